aes_axis_dwconv_128to32: RTL
============================

# aes_axis_dwconv_128to32

AXI-stream width down-converter that consumes the 128-bit `m_axis` output of `aes256_ctr_mode` and re-emits each block as four 32-bit words, most-significant word first, for the 32-bit DMA/UART side of the design. It is the receiving end of the core's output stream. It fully honours backpressure on both sides and carries `tlast` through to the final word of the last block. A completed-packet counter is exported for the status register.

## Interface
- `IN_WIDTH`, 128, input beat width; fixed to 128.
- `OUT_WIDTH`, 32, output word width; `IN_WIDTH % OUT_WIDTH == 0` required; `RATIO = IN_WIDTH/OUT_WIDTH` (4).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `s_axis_tvalid`  in  1  input beat valid.
- `s_axis_tready`  out  1  converter can accept a beat.
- `s_axis_tlast`  in  1  beat is last of packet.
- `s_axis_tdata`  in  128  ciphertext/plaintext block.
- `m_axis_tvalid`  out  1  output word valid.
- `m_axis_tready`  in  1  downstream accepts word.
- `m_axis_tlast`  out  1  last word of packet.
- `m_axis_tdata`  out  32  output word.
- `pkt_count`  out  16  count of packets fully emitted (words with `m_axis_tlast` accepted).

## Operation
- Holding register `hold[127:0]`, flag `hold_last`, state bit `full`, word index `idx[1:0]`.
- Input handshake: beat transfers when `s_axis_tvalid & s_axis_tready` at a rising edge. The beat is loaded into `hold`, `full` is set, and `idx` is set to 0.
- Output: `m_axis_tdata = hold[127-32*idx -: 32]`, so word 0 is `hold[127:96]`. `m_axis_tvalid = full`. `m_axis_tlast = full & hold_last & (idx == RATIO-1)`.
- Output handshake when `m_axis_tvalid & m_axis_tready`:
  - If `idx < RATIO-1`, `idx` increments.
  - If `idx == RATIO-1`, the block is done. `full` clears unless a new beat is loaded in the same cycle.
- `s_axis_tready = ~full | (m_axis_tvalid & m_axis_tready & idx == RATIO-1)`. This path is combinational from `m_axis_tready`, and `s_axis_tready` is forced to 0 while `rst` is asserted.
- Simultaneous last-word-out and new-beat-in: the new beat wins. `hold` is reloaded, `full` stays 1, `idx` goes to 0, and there is no bubble.
- `pkt_count` increments on each accepted word with `m_axis_tlast=1` and wraps from 0xFFFF to 0.
- `tdata` and `tlast` are never changed while `m_axis_tvalid=1` and `m_axis_tready=0` (AXI stability).
- Reset mid-block discards `hold`. No partial word is emitted afterwards.

## Timing
- Reset values: `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `s_axis_tready=0` while in reset. `full=0`, `idx=0`, `pkt_count=0`.
- First cycle after reset release: `s_axis_tready=1`.
- Latency: beat accepted at edge N gives word 0 valid in cycle N+1.
- Throughput: 1 word/cycle sustained with `m_axis_tready=1`, i.e. 1 input beat per 4 cycles, with no idle cycle between blocks.
- Backpressure: every cycle with `m_axis_tready=0` stalls by one cycle. `s_axis_tready` stays 0 while `full` and not on the final handshake.

## Configuration
- Macro `AES_DWCONV_PREFETCH_EN`.
- Defined: a second 128-bit entry (`next`, `next_last`, `next_full`) is added.
  - `s_axis_tready = ~next_full`, driven from registers only, with no combinational path from `m_axis_tready`.
  - When `hold` empties, it loads from `next` on the same edge.
  - Word order, tlast, and `pkt_count` rules are unchanged. Throughput is still 1 word/cycle, and latency is still 1 cycle into an empty converter.
- Undefined: single-register behaviour as above.

## Test plan
- Single beat `F3EED1BD_B5D2A03C_064B5A7E_3DB181F8` with tlast=1 and `m_axis_tready=1` -> words F3EED1BD, B5D2A03C, 064B5A7E, 3DB181F8 on cycles N+1..N+4. tlast only on 3DB181F8. `pkt_count`=1.
- Four back-to-back beats (F3EE…81F8, 591CCB10…31362870, B6ED21B9…BEAFED1D, 23304B7A…9E24ECC7; tlast on the fourth) -> 16 consecutive valid words with no bubble. tlast only on word 16 (9E24ECC7). `pkt_count`=1.
- `m_axis_tready` toggling 1,0,0,1,… during a block -> `m_axis_tdata` and `m_axis_tlast` hold steady while stalled. `s_axis_tready`=0 until the final word handshake. No word is lost or duplicated.
- Input valid presented on the same cycle as the last-word handshake -> accepted in that cycle. The next word 0 appears the following cycle.
- `rst` pulsed after word 1 of a block -> `m_axis_tvalid`=0 immediately (async). `pkt_count`=0. The next beat starts at word 0.
- With `AES_DWCONV_PREFETCH_EN`: two beats accepted while `m_axis_tready`=0, third beat sees `s_axis_tready`=0. `s_axis_tready` shows no combinational dependence on `m_axis_tready` (toggle it with `next_full` fixed and check `s_axis_tready` is unchanged).

Source files
------------

// File: rtl/aes_axis_dwconv_128to32.sv
// AXI-stream 128-to-32 width down-converter, most-significant word first, with tlast on the final word.
// Optional macro AES_DWCONV_PREFETCH_EN adds a second block buffer so s_axis_tready comes from a register.
module aes_axis_dwconv_128to32 #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic [15:0]          pkt_count
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [IN_WIDTH-1:0] hold;
    logic                hold_last;
    logic                full;
    logic [IDX_W-1:0]    idx;
    logic [IN_WIDTH-1:0] hold_shift;

    logic                out_fire;
    logic                last_fire;
    logic                hold_free;
    logic                in_fire;
    logic                load_hold;
    logic [IN_WIDTH-1:0] hold_src_data;
    logic                hold_src_last;

    assign out_fire  = full & m_axis_tready;
    assign last_fire = out_fire & (idx == LAST_IDX);
    assign hold_free = ~full | last_fire;
    assign in_fire   = s_axis_tvalid & s_axis_tready;

`ifdef AES_DWCONV_PREFETCH_EN
    logic [IN_WIDTH-1:0] next_data;
    logic                next_last;
    logic                next_full;
    logic                load_next;
    logic                refill;

    // Ready depends only on the prefetch slot, never on the downstream ready.
    assign s_axis_tready = ~rst & ~next_full;
    assign refill        = hold_free & next_full;
    assign load_next     = in_fire & ~hold_free;
    assign load_hold     = refill | (in_fire & hold_free);
    assign hold_src_data = next_full ? next_data : s_axis_tdata;
    assign hold_src_last = next_full ? next_last : s_axis_tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_full <= 1'b0;
        end else if (load_next) begin
            next_full <= 1'b1;
        end else if (refill) begin
            next_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_next) begin
            next_data <= s_axis_tdata;
            next_last <= s_axis_tlast;
        end
    end
`else
    // A new beat can land on the same edge the last word leaves, so blocks run back to back.
    assign s_axis_tready = ~rst & hold_free;
    assign load_hold     = in_fire;
    assign hold_src_data = s_axis_tdata;
    assign hold_src_last = s_axis_tlast;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= 1'b0;
            idx       <= '0;
            pkt_count <= '0;
        end else begin
            if (load_hold) begin
                full <= 1'b1;
                idx  <= '0;
            end else if (last_fire) begin
                full <= 1'b0;
            end else if (out_fire) begin
                idx <= idx + 1'b1;
            end
            if (out_fire & m_axis_tlast) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

    // Payload registers carry no reset; outputs are gated by full instead.
    always_ff @(posedge clk) begin
        if (load_hold) begin
            hold      <= hold_src_data;
            hold_last <= hold_src_last;
        end
    end

    assign hold_shift    = hold << (OUT_WIDTH * idx);
    assign m_axis_tvalid = full;
    assign m_axis_tlast  = full & hold_last & (idx == LAST_IDX);
    assign m_axis_tdata  = full ? hold_shift[IN_WIDTH-1 -: OUT_WIDTH] : '0;

endmodule
